load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one RISC-V data-memory access at a time between
// the pipeline request/response handshake and a single-port byte memory.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [1:0] OP_SW   = 2'b00;
  localparam logic [1:0] OP_SH   = 2'b01;
  localparam logic [1:0] OP_SB   = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  state_t      state_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        valid_q;
  logic [1:0]  we_q;

  logic        f3_ok;
  logic [32:0] size;
  logic [32:0] end_addr;
  logic        illegal;
  logic [1:0]  st_op;
  logic [31:0] ld_ext;

  // Decode the incoming request: funct3 legality, access size and range check
  // done at 33 bits so addresses near 2^32 cannot wrap back into range.
  always_comb begin
    f3_ok = 1'b0;
    if (req_store) f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                           (req_funct3 == 3'b010);
    else           f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                           (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                           (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b00:   size = 33'd1;
      2'b01:   size = 33'd2;
      default: size = 33'd4;
    endcase
    end_addr = {1'b0, req_addr} + size;
    illegal  = !f3_ok || (end_addr > 33'(MEM_BYTES));
    st_op    = req_funct3[1] ? OP_SW : (req_funct3[0] ? OP_SH : OP_SB);
  end

  // Extend the captured memory word according to the latched load type.
  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
      3'b001:  ld_ext = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
      3'b100:  ld_ext = {24'b0, mem_data_out[7:0]};
      3'b101:  ld_ext = {16'b0, mem_data_out[15:0]};
      default: ld_ext = mem_data_out;
    endcase
  end

  // Request sequencer; the write strobe is only ever non-read for the single
  // ACCESS cycle of a legal store, and reset drops it to read immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      we_q     <= OP_READ;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          store_q  <= req_store;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          rdata_q  <= 32'b0;
          if (illegal) begin
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            err_q   <= 1'b0;
            we_q    <= req_store ? st_op : OP_READ;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          we_q <= OP_READ;
          if (store_q) begin
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= ld_ext;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (resp_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = valid_q;
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign mem_write_en = we_q;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model with registered reads,
// vector table of accesses checked through an expectation queue, plus
// hand-written back-pressure and reset-during-store sequences.
module tb_load_store_unit;
  localparam int MB = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'b0;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: little-endian bytes, reads registered, misaligned wraps in-array
  logic [7:0]  mem [MB];
  logic [11:0] a0, a1, a2, a3;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'b0;
  assign a0 = mem_addr[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;

  always @(posedge clk) begin
    if (mem_write_en == 2'b11) begin
      mem_data_out <= {mem[a3], mem[a2], mem[a1], mem[a0]};
    end else begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      mem[a0] <= mem_data_in[7:0];
      if (mem_write_en != 2'b10) mem[a1] <= mem_data_in[15:8];
      if (mem_write_en == 2'b00) begin
        mem[a2] <= mem_data_in[23:16];
        mem[a3] <= mem_data_in[31:24];
      end
    end
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input vec_t v, input int hold);
    exp_t        e;
    int          lat;
    int          w0;
    int          guard;
    logic [31:0] rd0;
    logic        er0;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.lat   = v.lat;
    e.wr    = (v.st && !v.err) ? 1 : 0;
    sbq.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = v.st;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rdata", resp_rdata, e.rdata);
    chk("err", 32'(resp_err), 32'(e.err));
    chk("ready_busy", 32'(req_ready), 32'd0);
    rd0 = resp_rdata;
    er0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd0);
      chk("hold_err", 32'(resp_err), 32'(er0));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("consumed", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    chk("write_count", 32'(wr_cnt - w0), 32'(e.wr));
    if (e.wr == 1) chk("write_addr", wr_addr, v.addr);
  endtask

  vec_t tv[21];
  vec_t bp;
  int   w0;

  initial begin
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;

    //        st    f3      addr           wdata          rdata          err  lat
    tv[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 2};
    tv[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    tv[2]  = '{1'b1, 3'b000, 32'h0000_0021, 32'hAAAAAA80, 32'h0000_0000, 1'b0, 2};
    tv[3]  = '{1'b0, 3'b000, 32'h0000_0021, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    tv[4]  = '{1'b0, 3'b100, 32'h0000_0021, 32'h0,        32'h0000_0080, 1'b0, 3};
    tv[5]  = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,        32'hFFFFBEEF, 1'b0, 3};
    tv[6]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,        32'h0000DEAD, 1'b0, 3};
    tv[7]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b1, 1};
    tv[8]  = '{1'b1, 3'b010, 32'd4094,      32'h11223344, 32'h0000_0000, 1'b1, 1};
    tv[9]  = '{1'b1, 3'b100, 32'h0000_0030, 32'h55667788, 32'h0000_0000, 1'b1, 1};
    tv[10] = '{1'b1, 3'b010, 32'd4092,      32'hCAFEF00D, 32'h0000_0000, 1'b0, 2};
    tv[11] = '{1'b0, 3'b010, 32'd4092,      32'h0,        32'hCAFEF00D, 1'b0, 3};
    tv[12] = '{1'b0, 3'b100, 32'd4095,      32'h0,        32'h0000_00CA, 1'b0, 3};
    tv[13] = '{1'b0, 3'b000, 32'd4096,      32'h0,        32'h0000_0000, 1'b1, 1};
    tv[14] = '{1'b1, 3'b001, 32'h0000_0013, 32'h1234BEEF, 32'h0000_0000, 1'b0, 2};
    tv[15] = '{1'b0, 3'b101, 32'h0000_0013, 32'h0,        32'h0000BEEF, 1'b0, 3};
    tv[16] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hEFADBEEF, 1'b0, 3};
    tv[17] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,        32'h0000_0000, 1'b1, 1};
    tv[18] = '{1'b0, 3'b001, 32'h0000_0020, 32'h0,        32'hFFFF8000, 1'b0, 3};
    tv[19] = '{1'b1, 3'b001, 32'd4095,      32'h0000FFFF, 32'h0000_0000, 1'b1, 1};
    tv[20] = '{1'b0, 3'b110, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1, 1};

    // reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_write_en), 32'd3);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_data_in, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 21; i++) do_req(tv[i], 0);

    // back-pressure: response held five cycles
    bp = '{1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hEFADBEEF, 1'b0, 3};
    do_req(bp, 5);

    // reset asserted while a store is in ACCESS
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0040;
    req_wdata  = 32'h12345678;
    chk("mid_ready", 32'(req_ready), 32'd1);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_access_we", 32'(mem_write_en), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_write_en), 32'd3);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("mid_no_write", 32'(wr_cnt - w0), 32'd0);
    bp = '{1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0, 3};
    do_req(bp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
